// File: rtl/io_pkg.sv
// Shared definitions for the IO timer: register offsets, CTRL/STATUS bit
// positions, counter widths and the prescaler terminal-count helper.
package io_pkg;

   localparam int IO_ADDR_W  = 5;
   localparam int IO_DATA_W  = 8;
   localparam int COUNT_W    = 16;
   localparam int PSC_CNT_W  = 7;

   typedef enum logic [2:0] {
      OFF_CTRL      = 3'd0,
      OFF_STATUS    = 3'd1,
      OFF_COUNT_LO  = 3'd2,
      OFF_COUNT_HI  = 3'd3,
      OFF_RELOAD_LO = 3'd4,
      OFF_RELOAD_HI = 3'd5
   } io_off_e;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_AR      = 1;
   localparam int CTRL_IE      = 2;
   localparam int CTRL_PSC_LSB = 4;
   localparam logic [7:0] CTRL_MASK = 8'h77;

   localparam int STATUS_OVF = 0;

   // Prescaler terminal count for a period of 2^psc cycles.
   function automatic logic [PSC_CNT_W-1:0] psc_mask(input logic [2:0] psc);
      return ~({PSC_CNT_W{1'b1}} << psc);
   endfunction

endpackage

// File: rtl/io_timer_if.sv
// IO bus bundle between the processor-side IO decoder and the timer.
interface io_timer_if;
   logic                          pause;
   logic [io_pkg::IO_ADDR_W-1:0]  io_readaddr;
   logic [io_pkg::IO_DATA_W-1:0]  io_readdata;
   logic [io_pkg::IO_ADDR_W-1:0]  io_writeaddr;
   logic [io_pkg::IO_DATA_W-1:0]  io_writedata;
   logic                          io_write_en;

   modport master (
      output pause, io_readaddr, io_writeaddr, io_writedata, io_write_en,
      input  io_readdata
   );

   modport slave (
      input  pause, io_readaddr, io_writeaddr, io_writedata, io_write_en,
      output io_readdata
   );
endinterface

// File: rtl/io_prescaler.sv
// Timer prescaler: one tick every 2^psc enabled cycles; restarts on clr or
// while disabled, and a clr cycle never ticks.
module io_prescaler
   import io_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [2:0] psc,
   input  logic       clr,
   output logic       tick
);

   logic [PSC_CNT_W-1:0] cnt_q, cnt_d;
   logic                 at_tc;

   assign at_tc = (cnt_q == psc_mask(psc));
   assign tick  = en && !clr && at_tc;

   always_comb begin
      cnt_d = cnt_q + PSC_CNT_W'(1);
      if (clr || !en || at_tc)
         cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/io_timer.sv
// 16-bit down-counting IO timer with prescaler, auto-reload and level irq.
// Optional macro IO_TIMER_SNAPSHOT_EN: COUNT_HI reads return the high byte latched by the last COUNT_LO read.
module io_timer
   import io_pkg::*;
#(
   parameter logic [1:0] BANK = 2'd0
)(
   input  logic        clk,
   input  logic        reset,
   io_timer_if.slave   bus,
   output logic        irq
);

   logic [7:0]         ctrl_q, ctrl_d;
   logic               ovf_q, ovf_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [COUNT_W-1:0] reload_q, reload_d;
   logic [7:0]         stage_q, stage_d;
   logic [7:0]         rdata_q, rdata_d;
   logic [7:0]         rd_val, cnt_hi_rd;

   logic       wr_hit, rd_hit, ctrl_wr, tick, ovf_evt;
   logic [2:0] wr_off, rd_off;
   logic [7:0] wdata;

   assign wr_hit  = bus.io_write_en && (bus.io_writeaddr[4:3] == BANK);
   assign wr_off  = bus.io_writeaddr[2:0];
   assign wdata   = bus.io_writedata;
   assign rd_hit  = (bus.io_readaddr[4:3] == BANK);
   assign rd_off  = bus.io_readaddr[2:0];
   assign ctrl_wr = wr_hit && (wr_off == OFF_CTRL);

   io_prescaler u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (ctrl_q[CTRL_EN]),
      .psc   (ctrl_q[CTRL_PSC_LSB +: 3]),
      .clr   (ctrl_wr),
      .tick  (tick)
   );

   assign ovf_evt = tick && (count_q == '0);

`ifdef IO_TIMER_SNAPSHOT_EN
   logic [7:0] shadow_q, shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (!bus.pause && rd_hit && (rd_off == OFF_COUNT_LO))
         shadow_d = count_q[15:8];
   end

   always_ff @(posedge clk) begin
      if (reset)
         shadow_q <= '0;
      else
         shadow_q <= shadow_d;
   end

   assign cnt_hi_rd = shadow_q;
`else
   assign cnt_hi_rd = count_q[15:8];
`endif

   always_comb begin
      rd_val = 8'h00;
      if (rd_hit) begin
         case (rd_off)
            OFF_CTRL:      rd_val = ctrl_q;
            OFF_STATUS:    rd_val = {7'b0, ovf_q};
            OFF_COUNT_LO:  rd_val = count_q[7:0];
            OFF_COUNT_HI:  rd_val = cnt_hi_rd;
            OFF_RELOAD_LO: rd_val = reload_q[7:0];
            OFF_RELOAD_HI: rd_val = reload_q[15:8];
            default:       rd_val = 8'h00;
         endcase
      end
      rdata_d = bus.pause ? rdata_q : rd_val;
   end

   // Register writes are applied after the tick effects so they win where they must.
   always_comb begin
      ctrl_d   = ctrl_q;
      ovf_d    = ovf_q;
      count_d  = count_q;
      reload_d = reload_q;
      stage_d  = stage_q;

      if (tick) begin
         if (count_q != '0)
            count_d = count_q - COUNT_W'(1);
         else if (ctrl_q[CTRL_AR])
            count_d = reload_q;
      end

      if (ovf_evt && !ctrl_q[CTRL_AR])
         ctrl_d[CTRL_EN] = 1'b0;

      if (wr_hit) begin
         case (wr_off)
            OFF_CTRL:      ctrl_d = wdata & CTRL_MASK;
            OFF_STATUS:    if (wdata[STATUS_OVF]) ovf_d = 1'b0;
            OFF_COUNT_LO:  count_d = {stage_q, wdata};
            OFF_COUNT_HI:  stage_d = wdata;
            OFF_RELOAD_LO: reload_d[7:0] = wdata;
            OFF_RELOAD_HI: reload_d[15:8] = wdata;
            default:       ;
         endcase
      end

      if (ovf_evt)
         ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q   <= '0;
         ovf_q    <= 1'b0;
         count_q  <= '0;
         reload_q <= '0;
         stage_q  <= '0;
         rdata_q  <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         ovf_q    <= ovf_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         stage_q  <= stage_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.io_readdata = rdata_q;
   assign irq             = ovf_q & ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: directed scenarios plus random traffic
// checked every cycle against a cycle-level behavioural model.
module tb_io_timer;

   localparam logic [1:0] BANK = 2'd1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq;

   io_timer_if bus ();

   io_timer #(.BANK(BANK)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0]  m_ctrl, m_stage, m_rd, m_shadow;
   logic        m_ovf;
   logic [15:0] m_count, m_reload;
   int          m_elapsed;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_regval(input logic [2:0] off);
      case (off)
         3'd0: return m_ctrl;
         3'd1: return {7'b0, m_ovf};
         3'd2: return m_count[7:0];
`ifdef IO_TIMER_SNAPSHOT_EN
         3'd3: return m_shadow;
`else
         3'd3: return m_count[15:8];
`endif
         3'd4: return m_reload[7:0];
         3'd5: return m_reload[15:8];
         default: return 8'h00;
      endcase
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic       wr, ctrl_wr, tick, ovf_now, ar, en;
      logic [2:0] wo, ro;
      logic [7:0] wd;
      int         period;
      logic [15:0] n_count;
      logic [7:0]  n_ctrl;
      logic        n_ovf;
      if (rst) begin
         m_ctrl = 0; m_stage = 0; m_rd = 0; m_shadow = 0;
         m_ovf = 0; m_count = 0; m_reload = 0; m_elapsed = 0;
         return;
      end
      wr      = bus.io_write_en && (bus.io_writeaddr[4:3] == BANK);
      wo      = bus.io_writeaddr[2:0];
      wd      = bus.io_writedata;
      ro      = bus.io_readaddr[2:0];
      ctrl_wr = wr && (wo == 3'd0);
      en      = m_ctrl[0];
      ar      = m_ctrl[1];
      period  = 1 << m_ctrl[6:4];
      tick    = en && !ctrl_wr && ((m_elapsed % period) == period - 1);
      ovf_now = tick && (m_count == 16'd0);

      if (!bus.pause) begin
         m_rd = (bus.io_readaddr[4:3] == BANK) ? m_regval(ro) : 8'h00;
         if (bus.io_readaddr[4:3] == BANK && ro == 3'd2)
            m_shadow = m_count[15:8];
      end

      n_count = m_count;
      if (tick && m_count != 0) n_count = m_count - 16'd1;
      else if (tick && ar)      n_count = m_reload;
      if (wr && wo == 3'd2)     n_count = {m_stage, wd};

      n_ctrl = m_ctrl;
      if (ctrl_wr)              n_ctrl = wd & 8'h77;
      else if (ovf_now && !ar)  n_ctrl[0] = 1'b0;

      n_ovf = m_ovf;
      if (wr && wo == 3'd1 && wd[0]) n_ovf = 1'b0;
      if (ovf_now)                   n_ovf = 1'b1;

      if (wr && wo == 3'd3) m_stage = wd;
      if (wr && wo == 3'd4) m_reload[7:0] = wd;
      if (wr && wo == 3'd5) m_reload[15:8] = wd;

      m_elapsed = (ctrl_wr || !en) ? 0 : m_elapsed + 1;
      m_count   = n_count;
      m_ctrl    = n_ctrl;
      m_ovf     = n_ovf;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk("rdata", {24'b0, bus.io_readdata}, {24'b0, m_rd});
      chk("irq", {31'b0, irq}, {31'b0, m_ovf & m_ctrl[2]});
   endtask

   task automatic wr_bank(input logic [1:0] bank, input logic [2:0] off, input logic [7:0] d);
      bus.io_writeaddr = {bank, off};
      bus.io_writedata = d;
      bus.io_write_en  = 1'b1;
      step();
      bus.io_write_en  = 1'b0;
   endtask

   task automatic wr(input logic [2:0] off, input logic [7:0] d);
      wr_bank(BANK, off, d);
   endtask

   task automatic rd(input logic [2:0] off, output logic [7:0] v);
      bus.io_readaddr = {BANK, off};
      step();
      v = bus.io_readdata;
   endtask

   logic [7:0] v;
   logic [7:0] seq029 [4];
   logic [7:0] exp033 [6];

   initial begin
      seq029 = '{8'h03, 8'h02, 8'h01, 8'h00};
      exp033 = '{8'h00, 8'h00, 8'h55, 8'h00, 8'h03, 8'h00};
      bus.pause = 0; bus.io_readaddr = 0; bus.io_writeaddr = 0;
      bus.io_writedata = 0; bus.io_write_en = 0;

      // Reset state
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), v);
         chk("reset_reg", {24'b0, v}, 32'h0);
      end

      // Auto-reload every 4 ticks: 3,2,1,0,3...
      wr(3'd4, 8'h03); wr(3'd5, 8'h00);
      bus.io_readaddr = {BANK, 3'd2};
      wr(3'd0, 8'h03);
      for (int k = 1; k <= 9; k++) begin
         step();
         chk("autoreload_seq", {24'b0, bus.io_readdata},
             (k == 1) ? 32'h0 : {24'b0, seq029[(k - 2) % 4]});
      end
      wr(3'd0, 8'h00);
      wr(3'd1, 8'h01);

      // Atomic count load, first decrement 4 cycles after CTRL write (psc=2)
      wr(3'd3, 8'h12); wr(3'd2, 8'h34);
      bus.io_readaddr = {BANK, 3'd2};
      wr(3'd0, 8'h21);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("psc2_first_dec", {24'b0, bus.io_readdata}, (k < 5) ? 32'h34 : 32'h33);
      end
      wr(3'd0, 8'h00);

      // One-shot overflow clears en; W1C loses to a same-cycle overflow
      wr(3'd3, 8'h00); wr(3'd2, 8'h00);
      bus.io_readaddr = {BANK, 3'd0};
      wr(3'd0, 8'h05);
      step();
      chk("oneshot_irq", {31'b0, irq}, 32'h1);
      step();
      chk("oneshot_ctrl", {24'b0, bus.io_readdata}, 32'h04);
      wr(3'd0, 8'h05);
      wr(3'd1, 8'h01);
      rd(3'd1, v);
      chk("ovf_set_wins", {24'b0, v}, 32'h1);
      wr(3'd1, 8'h01);
      rd(3'd1, v);
      chk("ovf_w1c", {24'b0, v}, 32'h0);

      // Snapshot of the high byte on a COUNT_LO read
      wr(3'd0, 8'h00);
      wr(3'd3, 8'h01); wr(3'd2, 8'h00);
      wr(3'd0, 8'h31);
      rd(3'd2, v);
      chk("snap_lo", {24'b0, v}, 32'h00);
      bus.io_readaddr = {BANK, 3'd0};
      for (int k = 0; k < 8; k++) step();
      rd(3'd3, v);
`ifdef IO_TIMER_SNAPSHOT_EN
      chk("snap_hi", {24'b0, v}, 32'h01);
`else
      chk("snap_hi", {24'b0, v}, 32'h00);
`endif
      wr(3'd0, 8'h00);

      // Pause holds read data; foreign-bank writes are ignored
      wr(3'd3, 8'h00); wr(3'd2, 8'h55);
      rd(3'd2, v);
      chk("pre_pause", {24'b0, v}, 32'h55);
      bus.pause = 1'b1;
      bus.io_readaddr = {BANK, 3'd0};
      for (int k = 0; k < 3; k++) begin
         step();
         chk("pause_hold", {24'b0, bus.io_readdata}, 32'h55);
      end
      bus.pause = 1'b0;
      for (int i = 0; i < 6; i++) wr_bank(2'd2, 3'(i), 8'hFF);
      for (int i = 0; i < 6; i++) begin
         rd(3'(i), v);
         chk("bank_mismatch", {24'b0, v}, {24'b0, exp033[i]});
      end

      // Reset beats a same-cycle CTRL write while counting
      wr(3'd4, 8'h02); wr(3'd0, 8'h07);
      step(); step(); step();
      rst = 1'b1;
      bus.io_writeaddr = {BANK, 3'd0};
      bus.io_writedata = 8'h07;
      bus.io_write_en  = 1'b1;
      step();
      rst = 1'b0;
      bus.io_write_en = 1'b0;
      chk("reset_irq", {31'b0, irq}, 32'h0);
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), v);
         chk("reset_mid_count", {24'b0, v}, 32'h0);
      end

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst              = ($urandom_range(0, 299) == 0);
         bus.pause        = ($urandom_range(0, 3) == 0);
         bus.io_readaddr  = {($urandom_range(0, 4) == 0) ? 2'($urandom) : BANK, 3'($urandom)};
         bus.io_writeaddr = {($urandom_range(0, 4) == 0) ? 2'($urandom) : BANK, 3'($urandom)};
         bus.io_writedata = 8'($urandom);
         if (bus.io_writeaddr[2:0] == 3'd0 && $urandom_range(0, 1) == 0)
            bus.io_writedata[6:4] = 3'($urandom_range(0, 1));
         bus.io_write_en  = ($urandom_range(0, 3) == 0);
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
